// File: rtl/flow_ctrl.sv
// flow_ctrl: program counter, return stack and prioritised interrupt unit; nesting when FLOW_CTRL_NEST_EN is defined
module flow_ctrl #(
  parameter int MINSTW = 9,
  parameter int SDEPTH = 8,
  parameter int NUITRS = 4,
  parameter int RSTADD = 0,
  parameter int ITRADD = 16,
  parameter int ITRSTP = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        jmp,
  input  logic [MINSTW-1:0]           jmp_addr,
  input  logic                        cal,
  input  logic                        ret,
  input  logic                        reti,
  input  logic                        ie_set,
  input  logic                        ie_clr,
  input  logic [NUITRS-1:0]           itr_req,
  input  logic                        clr_err,
  output logic [MINSTW-1:0]           pc,
  output logic [NUITRS-1:0]           itr_ack,
  output logic                        itr_active,
  output logic [$clog2(SDEPTH+1)-1:0] stk_lvl,
  output logic                        stk_ovf,
  output logic                        stk_unf
);
  localparam int LW = $clog2(SDEPTH+1);
  localparam int AW = $clog2(SDEPTH);
  localparam int SW = NUITRS > 1 ? $clog2(NUITRS) : 1;
  localparam logic [LW-1:0] FULL = LW'(SDEPTH);
  logic [MINSTW-1:0] stk [SDEPTH];
  logic [NUITRS-1:0] pend, req_q, isr, acc;
  logic ie, excl, hit, seen, push, pop, ovf_e, unf_e, isr_clr;
  logic [SW-1:0] idx;
  logic [MINSTW-1:0] pc_n, push_d, top, vec;
  assign top = stk[stk_lvl[AW-1:0] - AW'(1)];
  assign vec = MINSTW'(ITRADD + int'(idx) * ITRSTP);
  assign acc = (en && hit) ? NUITRS'(1) << idx : '0;
  assign itr_active = |isr;
`ifdef FLOW_CTRL_NEST_EN
  assign excl = 1'b1;
  // in-service mask, one bit per nested level; reti retires the lowest set bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) isr <= '0;
    else isr <= isr_clr ? isr & (isr - NUITRS'(1)) : isr | acc;
`else
  logic act;
  logic [SW-1:0] src;
  assign excl = ~act;
  assign isr = act ? NUITRS'(1) << src : '0;
  // single in-service flag plus the index of the source being served
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      act <= 1'b0;
      src <= '0;
    end else begin
      act <= isr_clr ? 1'b0 : (|acc) ? 1'b1 : act;
      src <= (|acc) ? idx : src;
    end
`endif
  // lowest-index pending source not masked by an equal-or-higher priority level in service
  always_comb begin
    seen = 1'b0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUITRS; i++) begin
      seen = seen | isr[i];
      if (!hit && ie && excl && stk_lvl != FULL && pend[i] && !seen) begin
        hit = 1'b1;
        idx = SW'(i);
      end
    end
  end
  // one action per enabled cycle: entry, return, call, jump, then sequential advance
  always_comb begin
    pc_n = pc + MINSTW'(1);
    push = 1'b0;
    pop = 1'b0;
    push_d = pc + MINSTW'(1);
    ovf_e = 1'b0;
    unf_e = 1'b0;
    isr_clr = 1'b0;
    if (!en) pc_n = pc;
    else if (hit) begin
      pc_n = vec;
      push = 1'b1;
      push_d = pc;
    end else if (ret || reti) begin
      isr_clr = reti;
      unf_e = stk_lvl == '0;
      pop = stk_lvl != '0;
      pc_n = pop ? top : pc_n;
    end else if (cal) begin
      pc_n = jmp_addr;
      ovf_e = stk_lvl == FULL;
      push = stk_lvl != FULL;
    end else if (jmp) pc_n = jmp_addr;
  end
  // control state: pc, occupancy, pending capture, enable and sticky errors
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= MINSTW'(RSTADD);
      stk_lvl <= '0;
      req_q <= '0;
      pend <= '0;
      ie <= 1'b0;
      itr_ack <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      pc <= pc_n;
      stk_lvl <= push ? stk_lvl + LW'(1) : pop ? stk_lvl - LW'(1) : stk_lvl;
      req_q <= itr_req;
      pend <= (pend & ~acc) | (itr_req & ~req_q);
      ie <= ie_clr ? 1'b0 : ie_set ? 1'b1 : ie;
      itr_ack <= acc;
      stk_ovf <= ovf_e | (stk_ovf & ~clr_err);
      stk_unf <= unf_e | (stk_unf & ~clr_err);
    end
  // return-stack storage; writes only below the full mark
  always_ff @(posedge clk)
    if (push) stk[stk_lvl[AW-1:0]] <= push_d;
endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed checks of flow_ctrl PC, stack, errors and interrupts
module tb_flow_ctrl;
  logic clk = 1'b0;
  logic rst, en, jmp, cal, ret, reti, ie_set, ie_clr, clr_err;
  logic [8:0] jmp_addr;
  logic [3:0] itr_req;
  logic [8:0] pc;
  logic [3:0] itr_ack;
  logic itr_active, stk_ovf, stk_unf;
  logic [3:0] stk_lvl;
  int tests = 0;
  int fails = 0;

  flow_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr), .cal(cal),
    .ret(ret), .reti(reti), .ie_set(ie_set), .ie_clr(ie_clr), .itr_req(itr_req),
    .clr_err(clr_err), .pc(pc), .itr_ack(itr_ack), .itr_active(itr_active),
    .stk_lvl(stk_lvl), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 0; jmp = 0; cal = 0; ret = 0; reti = 0;
    ie_set = 0; ie_clr = 0; clr_err = 0; jmp_addr = '0; itr_req = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_lvl", stk_lvl, 0);
    chk("rst_ack", itr_ack, 0);
    chk("rst_active", itr_active, 0);
    chk("rst_err", {stk_ovf, stk_unf}, 0);
    #6 rst = 1'b1; en = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", pc, i);
    end
    jmp = 1; jmp_addr = 9'd511;
    step(); chk("jmp_max", pc, 511);
    jmp = 0;
    step(); chk("wrap", pc, 0);
    jmp = 1; jmp_addr = 9'd3;
    step(); chk("jmp3", pc, 3);
    jmp = 0; cal = 1; jmp_addr = 9'd40;
    step(); chk("cal_pc", pc, 40); chk("cal_lvl", stk_lvl, 1);
    cal = 0; ret = 1;
    step(); chk("ret_pc", pc, 4); chk("ret_lvl", stk_lvl, 0);
    ret = 0; cal = 1;
    for (int i = 0; i <= 8; i++) begin
      jmp_addr = 9'(100 + i);
      step();
    end
    chk("ovf_flag", stk_ovf, 1); chk("ovf_lvl", stk_lvl, 8); chk("ovf_pc", pc, 108);
    cal = 0; ret = 1;
    for (int i = 0; i < 8; i++) step();
    chk("pop_all_pc", pc, 5); chk("pop_all_lvl", stk_lvl, 0);
    step(); chk("unf_flag", stk_unf, 1); chk("unf_pc", pc, 6); chk("ovf_kept", stk_ovf, 1);
    ret = 0; clr_err = 1;
    step(); chk("clr_err", {stk_ovf, stk_unf}, 0);
    ret = 1;
    step(); chk("err_beats_clr", {stk_ovf, stk_unf}, 1); chk("unf_pc2", pc, 8);
    ret = 0;
    step(); chk("clr_err2", stk_unf, 0);
    ie_set = 1; jmp = 1; jmp_addr = 9'd9;
    step(); chk("pc9", pc, 9);
    ie_set = 0; jmp = 0; itr_req = 4'b0100;
    step(); chk("pend_pc", pc, 10); chk("pend_noack", itr_ack, 0);
    step(); chk("ent2_pc", pc, 20); chk("ent2_ack", itr_ack, 4'b0100);
    chk("ent2_lvl", stk_lvl, 1); chk("ent2_act", itr_active, 1);
    step(); chk("ack_pulse", itr_ack, 0); chk("isr_pc", pc, 21);
    itr_req = 4'b1101;
    step(); chk("nest_cap_pc", pc, 22);
`ifdef FLOW_CTRL_NEST_EN
    step(); chk("ent0_pc", pc, 16); chk("ent0_lvl", stk_lvl, 2); chk("ent0_ack", itr_ack, 4'b0001);
    step(); chk("isr0_pc", pc, 17);
    reti = 1;
    step(); chk("reti1_pc", pc, 22); chk("reti1_act", itr_active, 1); chk("reti1_lvl", stk_lvl, 1);
    step(); chk("reti2_pc", pc, 10); chk("reti2_act", itr_active, 0); chk("reti2_ack", itr_ack, 0);
    reti = 0;
    step(); chk("ent3_pc", pc, 22); chk("ent3_ack", itr_ack, 4'b1000);
    reti = 1;
    step(); chk("reti3_pc", pc, 10);
`else
    step(); chk("single_blk_pc", pc, 23); chk("single_blk_ack", itr_ack, 0);
    reti = 1;
    step(); chk("reti1_pc", pc, 10); chk("reti1_act", itr_active, 0);
    reti = 0;
    step(); chk("ent0_pc", pc, 16); chk("ent0_ack", itr_ack, 4'b0001);
    reti = 1;
    step(); chk("reti2_pc", pc, 10);
    reti = 0;
    step(); chk("ent3_pc", pc, 22); chk("ent3_ack", itr_ack, 4'b1000);
    reti = 1;
    step(); chk("reti3_pc", pc, 10);
`endif
    reti = 0; itr_req = 4'b0000;
    step(); chk("idle_pc", pc, 11); chk("idle_lvl", stk_lvl, 0);
    itr_req = 4'b0010;
    step(); chk("p1_pc", pc, 12);
    cal = 1; jmp_addr = 9'd200;
    step(); chk("ent1_beats_cal_pc", pc, 18); chk("ent1_lvl", stk_lvl, 1); chk("ent1_ack", itr_ack, 4'b0010);
    cal = 0; reti = 1; itr_req = 4'b0000;
    step(); chk("ent1_ret_pc", pc, 12); chk("ent1_ret_lvl", stk_lvl, 0);
    reti = 0; ie_set = 1; ie_clr = 1; itr_req = 4'b0010;
    step(); chk("ieclr_pc", pc, 13);
    ie_set = 0; ie_clr = 0;
    step(); chk("ie_off_pc", pc, 14); chk("ie_off_ack", itr_ack, 0);
    step(); chk("ie_off_pc2", pc, 15);
    en = 0; ie_set = 1; itr_req = 4'b0110;
    step(); chk("stall_pc", pc, 15); chk("stall_ack", itr_ack, 0);
    ie_set = 0;
    step(); chk("stall_pc2", pc, 15);
    en = 1;
    step(); chk("unstall_pc", pc, 18); chk("unstall_ack", itr_ack, 4'b0010);
    reti = 1;
    step(); chk("unstall_ret", pc, 15); chk("unstall_ret_lvl", stk_lvl, 0);
    reti = 0;
    step(); chk("stall_ent2_pc", pc, 20); chk("stall_ent2_ack", itr_ack, 4'b0100);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 0); chk("mid_rst_lvl", stk_lvl, 0); chk("mid_rst_act", itr_active, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
